branch_rs: RTL
==============

# branch_rs

In-order reservation station that feeds the EX-stage branch unit. It accepts dispatched branch/jump micro-ops, holds them until both source operands are available, and issues the oldest one with a one-cycle `issue_o` pulse and registered operand/PC/immediate fields. It wakes up operands by snooping two writeback buses and is cleared whole on a pipeline kill (misprediction/exception).

## Interface
- `DEPTH`, 4: entry count, power of two, ≥2.
- `DATA_LEN`, 32: operand width.
- `ADDR_LEN`, 32: PC width.
- `TAG_LEN`, 6: rename-register (RRF) tag width.
- `OP_LEN`, 4: ALU op width.

Ports:
- `clk_i` in 1: single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `kill_i` in 1: flush all entries.
- `dp_valid_i` in 1: dispatch request.
- `dp_ready_o` out 1: `count_o < DEPTH`.
- `dp_alu_op_i` in OP_LEN; `dp_pc_i` in ADDR_LEN; `dp_imm_i` in DATA_LEN; `dp_opcode_i` in 1.
- `dp_src1_i`, `dp_src2_i` in DATA_LEN: value, or tag in `[TAG_LEN-1:0]` when not valid.
- `dp_valid1_i`, `dp_valid2_i` in 1: operand holds a value.
- `dp_rrftag_i` in TAG_LEN; `dp_dst_en_i` in 1: writes RRF.
- `wb0_valid_i`, `wb1_valid_i` in 1; `wb0_tag_i`, `wb1_tag_i` in TAG_LEN; `wb0_data_i`, `wb1_data_i` in DATA_LEN: result broadcasts.
- `ex_stall_i` in 1: branch unit cannot accept.
- `issue_o` out 1: one-cycle issue pulse.
- `alu_op_o`, `src1_o`, `src2_o`, `pc_o`, `imm_o`, `opcode_o`, `rrftag_o`, `if_write_rrf_o`: registered issue fields.
- `count_o` out log2(DEPTH)+1: occupied entries.

## Operation
- Storage: circular buffer, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus a count register. Per entry: all dispatch fields and `valid1`/`valid2` flags.
- Dispatch: a write occurs when `dp_valid_i & dp_ready_o & ~kill_i`. The entry is written at `tail`, then `tail++`. `dp_valid_i` while not ready is ignored and drops nothing internally.
- Dispatch bypass: if a dispatched operand is not valid and its tag equals a same-cycle valid `wbN_tag_i`, the entry stores `wbN_data_i` with its flag set.
- Wakeup: on every edge, each occupied entry with `validK==0` and a tag match on a valid writeback bus captures the data and sets `validK`. If both buses match, `wb0` wins.
- Selection: strictly in order. The head is eligible iff occupied, `valid1 & valid2` (stored flags, not same-cycle wakeup), `~ex_stall_i`, and `~kill_i`.
- Issue: on an eligible edge, the head fields load the output registers, `head++`, and `issue_o` is set for the following cycle. Otherwise `issue_o` goes to 0 and the output fields hold their last values.
- Count: +1 on dispatch, −1 on issue, unchanged when both occur in the same cycle. `dp_ready_o` uses the registered count, so a full station refuses dispatch even in a cycle that issues.
- Kill: head, tail, and count go to 0, all occupancy is cleared, and `issue_o` goes to 0 next cycle. Dispatch and issue in the kill cycle are suppressed.
- Reset: same as kill. All output data registers are 0, `issue_o`=0, `count_o`=0, and `dp_ready_o`=1 after reset.

## Timing
- Dispatch at edge N with both operands valid: eligible in cycle N..N+1, dequeued at edge N+1, `issue_o`=1 in cycle N+1..N+2. Minimum latency is 2 edges.
- An operand woken at edge M makes the entry eligible at edge M+1.
- Throughput: one issue per cycle when the head is ready and not stalled.
- `ex_stall_i` is sampled at the issue edge. A stall holds the head and keeps `issue_o` low.
- A non-ready head blocks younger ready entries (in-order issue).

## Test plan
- Reset, then dispatch one jump (pc=0x100, imm=0x20, src1=5, src2=7, both valid) -> `issue_o` pulses 2 edges later with pc_o=0x100, imm_o=0x20, src1_o=5, src2_o=7; `count_o` returns to 0.
- Dispatch an entry with src1 tag 0x0A not valid, then drive `wb1_valid_i=1`, tag 0x0A, data 0xDEAD 3 cycles later -> issues the edge after capture with src1_o=0xDEAD; no early issue.
- Dispatch an operand with tag 0x12 while `wb0` broadcasts tag 0x12 data 0x55 in the same cycle -> bypass captured, issue at minimum latency with src1_o=0x55.
- Fill 4 entries with the head not ready -> `dp_ready_o`=0 and a 5th dispatch is ignored. Wake the head -> four consecutive `issue_o` pulses in order, pointers wrap, and `count_o` goes 4→0.
- Hold `ex_stall_i`=1 for 3 cycles with a ready head -> no issue. Release -> issue the next edge with unchanged fields.
- With 3 entries queued, assert `kill_i` together with `dp_valid_i` -> `count_o`=0, no `issue_o` afterwards, and the dispatched op is dropped. A following dispatch issues normally from slot 0.

Source files
------------

// File: rtl/branch_rs.sv
// In-order reservation station for the branch unit: circular buffer of
// dispatched micro-ops, writeback-bus operand wakeup, oldest-first issue.
module branch_rs #(
  parameter int DEPTH    = 4,
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int TAG_LEN  = 6,
  parameter int OP_LEN   = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     kill_i,
  input  logic                     dp_valid_i,
  output logic                     dp_ready_o,
  input  logic [OP_LEN-1:0]        dp_alu_op_i,
  input  logic [ADDR_LEN-1:0]      dp_pc_i,
  input  logic [DATA_LEN-1:0]      dp_imm_i,
  input  logic                     dp_opcode_i,
  input  logic [DATA_LEN-1:0]      dp_src1_i,
  input  logic [DATA_LEN-1:0]      dp_src2_i,
  input  logic                     dp_valid1_i,
  input  logic                     dp_valid2_i,
  input  logic [TAG_LEN-1:0]       dp_rrftag_i,
  input  logic                     dp_dst_en_i,
  input  logic                     wb0_valid_i,
  input  logic                     wb1_valid_i,
  input  logic [TAG_LEN-1:0]       wb0_tag_i,
  input  logic [TAG_LEN-1:0]       wb1_tag_i,
  input  logic [DATA_LEN-1:0]      wb0_data_i,
  input  logic [DATA_LEN-1:0]      wb1_data_i,
  input  logic                     ex_stall_i,
  output logic                     issue_o,
  output logic [OP_LEN-1:0]        alu_op_o,
  output logic [DATA_LEN-1:0]      src1_o,
  output logic [DATA_LEN-1:0]      src2_o,
  output logic [ADDR_LEN-1:0]      pc_o,
  output logic [DATA_LEN-1:0]      imm_o,
  output logic                     opcode_o,
  output logic [TAG_LEN-1:0]       rrftag_o,
  output logic                     if_write_rrf_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [OP_LEN-1:0]   alu_op;
    logic [ADDR_LEN-1:0] pc;
    logic [DATA_LEN-1:0] imm;
    logic                opcode;
    logic [DATA_LEN-1:0] src1;
    logic [DATA_LEN-1:0] src2;
    logic [TAG_LEN-1:0]  rrftag;
    logic                dst_en;
  } out_t;

  typedef struct packed {
    out_t f;
    logic v1;
    logic v2;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  ent_t             nw;
  ent_t             hd;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  out_t             iss_q, iss_d;
  logic             issue_q, issue_d;
  logic             dp_we, iss_go;

  // Pending operands carry their tag in the low bits; wb0 has priority.
  function automatic logic [DATA_LEN:0] snoop(input logic vld, input logic [DATA_LEN-1:0] val);
    snoop = {vld, val};
    if (!vld) begin
      if (wb0_valid_i && wb0_tag_i == val[TAG_LEN-1:0])      snoop = {1'b1, wb0_data_i};
      else if (wb1_valid_i && wb1_tag_i == val[TAG_LEN-1:0]) snoop = {1'b1, wb1_data_i};
    end
  endfunction

  assign dp_ready_o = (count_q < CW'(DEPTH));
  assign dp_we      = dp_valid_i & dp_ready_o & ~kill_i;
  assign hd         = ent_q[head_q];
  assign iss_go     = busy_q[head_q] & hd.v1 & hd.v2 & ~ex_stall_i & ~kill_i;

  always_comb begin
    nw          = '0;
    nw.f.alu_op = dp_alu_op_i;
    nw.f.pc     = dp_pc_i;
    nw.f.imm    = dp_imm_i;
    nw.f.opcode = dp_opcode_i;
    nw.f.rrftag = dp_rrftag_i;
    nw.f.dst_en = dp_dst_en_i;
    {nw.v1, nw.f.src1} = snoop(dp_valid1_i, dp_src1_i);
    {nw.v2, nw.f.src2} = snoop(dp_valid2_i, dp_src2_i);
  end

  always_comb begin
    ent_d   = ent_q;
    busy_d  = busy_q;
    head_d  = head_q;
    tail_d  = tail_q;
    iss_d   = iss_q;
    issue_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i]) begin
        {ent_d[i].v1, ent_d[i].f.src1} = snoop(ent_q[i].v1, ent_q[i].f.src1);
        {ent_d[i].v2, ent_d[i].f.src2} = snoop(ent_q[i].v2, ent_q[i].f.src2);
      end
    end
    // The tail slot is never occupied while dispatch is allowed, so this cannot clash with wakeup.
    if (dp_we) begin
      ent_d[tail_q]  = nw;
      busy_d[tail_q] = 1'b1;
      tail_d         = tail_q + PW'(1);
    end
    if (iss_go) begin
      iss_d          = hd.f;
      busy_d[head_q] = 1'b0;
      head_d         = head_q + PW'(1);
      issue_d        = 1'b1;
    end
    count_d = count_q + CW'(dp_we) - CW'(iss_go);
    if (kill_i) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      iss_q   <= '0;
      issue_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      iss_q   <= iss_d;
      issue_q <= issue_d;
    end
  end

  // Entry payload needs no reset; occupancy is tracked by busy_q.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

  assign issue_o        = issue_q;
  assign alu_op_o       = iss_q.alu_op;
  assign src1_o         = iss_q.src1;
  assign src2_o         = iss_q.src2;
  assign pc_o           = iss_q.pc;
  assign imm_o          = iss_q.imm;
  assign opcode_o       = iss_q.opcode;
  assign rrftag_o       = iss_q.rrftag;
  assign if_write_rrf_o = iss_q.dst_en;
  assign count_o        = count_q;
endmodule
